// File: rtl/fpu_apu_arbiter.sv
// Round-robin arbiter sharing one fpu_alu APU port between N_REQ requesters.
// An in-order tag FIFO steers each response back to the requester that issued it.
module fpu_apu_arbiter #(
  parameter int N_REQ     = 2,
  parameter int MAX_OUTST = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N_REQ-1:0]     req_i,
  output logic [N_REQ-1:0]     gnt_o,
  input  logic [N_REQ*32-1:0]  op_a_i,
  input  logic [N_REQ*32-1:0]  op_b_i,
  input  logic [N_REQ*32-1:0]  op_c_i,
  input  logic [N_REQ*5-1:0]   op_code_i,
  input  logic [N_REQ*3-1:0]   rnd_mode_i,
  output logic [N_REQ-1:0]     rvalid_o,
  output logic [31:0]          rdata_o,
  output logic [4:0]           rflags_o,
  output logic                 apu_req_o,
  input  logic                 apu_gnt_i,
  output logic [31:0]          apu_operands_1_o,
  output logic [31:0]          apu_operands_2_o,
  output logic [31:0]          apu_operands_3_o,
  output logic [4:0]           apu_op_o,
  output logic [2:0]           fp_rnd_mode_o,
  input  logic                 apu_rvalid_i,
  input  logic [31:0]          apu_rdata_i,
  input  logic [4:0]           apu_rflags_i,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CNT_W = $clog2(MAX_OUTST) + 1;

  logic [IDX_W-1:0] rr_ptr_q, sel_q, rr_win, winner, cand_idx, head;
  logic             lock_q, any_req, not_full, accept, pop, err_q;
  logic [IDX_W-1:0] tag_mem [MAX_OUTST];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  int               cand;

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    rr_win   = rr_ptr_q;
    cand     = 0;
    cand_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand     = (int'(rr_ptr_q) + i) % N_REQ;
      cand_idx = IDX_W'(cand);
      if (req_i[cand_idx]) rr_win = cand_idx;
    end
  end

  assign winner    = lock_q ? sel_q : rr_win;
  assign any_req   = |req_i;
  assign not_full  = cnt_q < CNT_W'(MAX_OUTST);
  assign apu_req_o = any_req && not_full;
  assign accept    = apu_req_o && apu_gnt_i;
  assign pop       = apu_rvalid_i && (cnt_q != '0);
  assign head      = tag_mem[rd_ptr_q];
  assign busy_o    = cnt_q != '0;
  assign err_o     = err_q;

  always_comb begin
    gnt_o            = '0;
    rvalid_o         = '0;
    rdata_o          = '0;
    rflags_o         = '0;
    apu_operands_1_o = '0;
    apu_operands_2_o = '0;
    apu_operands_3_o = '0;
    apu_op_o         = '0;
    fp_rnd_mode_o    = '0;
    if (any_req) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (winner == IDX_W'(k)) begin
          apu_operands_1_o = op_a_i[32*k +: 32];
          apu_operands_2_o = op_b_i[32*k +: 32];
          apu_operands_3_o = op_c_i[32*k +: 32];
          apu_op_o         = op_code_i[5*k +: 5];
          fp_rnd_mode_o    = rnd_mode_i[3*k +: 3];
        end
      end
    end
    if (accept) gnt_o[winner] = 1'b1;
    if (pop) begin
      rvalid_o[head] = 1'b1;
      rdata_o        = apu_rdata_i;
      rflags_o       = apu_rflags_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) tag_mem[wr_ptr_q] <= winner;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
      sel_q    <= '0;
      lock_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        lock_q   <= 1'b0;
        rr_ptr_q <= (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end else if (apu_req_o) begin
        // Freeze the selection while the ALU stalls so the payload stays stable.
        lock_q <= 1'b1;
        sel_q  <= winner;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (apu_rvalid_i && (cnt_q == '0)) err_q <= 1'b1;
      case ({accept, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_apu_arbiter.sv
// Bench for fpu_apu_arbiter: directed scenarios plus random traffic checked
// against a queue-based reference model of arbitration and response routing.
module tb_fpu_apu_arbiter;
  localparam int N_REQ     = 2;
  localparam int MAX_OUTST = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [1:0]  req_i, gnt_o, rvalid_o;
  logic [63:0] op_a_i, op_b_i, op_c_i;
  logic [9:0]  op_code_i;
  logic [5:0]  rnd_mode_i;
  logic [31:0] rdata_o;
  logic [4:0]  rflags_o;
  logic        apu_req_o, apu_gnt_i;
  logic [31:0] apu_operands_1_o, apu_operands_2_o, apu_operands_3_o;
  logic [4:0]  apu_op_o;
  logic [2:0]  fp_rnd_mode_o;
  logic        apu_rvalid_i;
  logic [31:0] apu_rdata_i;
  logic [4:0]  apu_rflags_i;
  logic        busy_o, err_o;

  int checks = 0;
  int failures = 0;

  int         m_rr;
  bit         m_locked;
  int         m_held;
  int         m_tags[$];
  bit         m_err;
  logic [1:0] m_last_gnt;

  always #5 clk_i = ~clk_i;

  fpu_apu_arbiter #(.N_REQ(N_REQ), .MAX_OUTST(MAX_OUTST)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o),
    .op_a_i(op_a_i), .op_b_i(op_b_i), .op_c_i(op_c_i),
    .op_code_i(op_code_i), .rnd_mode_i(rnd_mode_i),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .rflags_o(rflags_o),
    .apu_req_o(apu_req_o), .apu_gnt_i(apu_gnt_i),
    .apu_operands_1_o(apu_operands_1_o), .apu_operands_2_o(apu_operands_2_o),
    .apu_operands_3_o(apu_operands_3_o), .apu_op_o(apu_op_o),
    .fp_rnd_mode_o(fp_rnd_mode_o), .apu_rvalid_i(apu_rvalid_i),
    .apu_rdata_i(apu_rdata_i), .apu_rflags_i(apu_rflags_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    req_i = '0; op_a_i = '0; op_b_i = '0; op_c_i = '0; op_code_i = '0; rnd_mode_i = '0;
    apu_gnt_i = 1'b0; apu_rvalid_i = 1'b0; apu_rdata_i = '0; apu_rflags_i = '0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    clear_inputs();
    m_rr = 0; m_locked = 0; m_held = 0; m_tags.delete(); m_err = 0; m_last_gnt = '0;
    #1;
    check("rst_gnt", gnt_o, 0);
    check("rst_rvalid", rvalid_o, 0);
    check("rst_apu_req", apu_req_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_err", err_o, 0);
    check("rst_rdata", rdata_o, 0);
    check("rst_rflags", rflags_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  // One clock: compare DUT against the model mid-cycle, then advance the model.
  task automatic step();
    bit   anyr, full, e_req, acc, pop;
    int   win, idx;
    logic [1:0] e_gnt, e_rv;
    #1;
    anyr  = |req_i;
    full  = (m_tags.size() == MAX_OUTST);
    e_req = anyr && !full;
    if (m_locked) win = m_held;
    else begin
      win = -1;
      for (int i = 0; i < N_REQ; i++) begin
        idx = (m_rr + i) % N_REQ;
        if (win < 0 && req_i[idx]) win = idx;
      end
      if (win < 0) win = 0;
    end
    acc   = e_req && apu_gnt_i;
    pop   = apu_rvalid_i && (m_tags.size() > 0);
    e_gnt = acc ? 2'(1 << win) : 2'b00;
    e_rv  = pop ? 2'(1 << m_tags[0]) : 2'b00;
    check("apu_req", apu_req_o, e_req);
    check("gnt", gnt_o, e_gnt);
    check("op_a", apu_operands_1_o, anyr ? op_a_i[32*win +: 32] : 32'h0);
    check("op_b", apu_operands_2_o, anyr ? op_b_i[32*win +: 32] : 32'h0);
    check("op_c", apu_operands_3_o, anyr ? op_c_i[32*win +: 32] : 32'h0);
    check("op_code", apu_op_o, anyr ? op_code_i[5*win +: 5] : 5'h0);
    check("rnd_mode", fp_rnd_mode_o, anyr ? rnd_mode_i[3*win +: 3] : 3'h0);
    check("rvalid", rvalid_o, e_rv);
    if (pop) begin
      check("rdata", rdata_o, apu_rdata_i);
      check("rflags", rflags_o, apu_rflags_i);
    end
    check("busy", busy_o, m_tags.size() != 0);
    check("err", err_o, m_err);
    @(posedge clk_i);
    if (e_req && !apu_gnt_i) begin m_locked = 1; m_held = win; end
    if (acc) begin m_locked = 0; m_rr = (win + 1) % N_REQ; end
    if (pop) void'(m_tags.pop_front());
    else if (apu_rvalid_i) m_err = 1;
    if (acc) m_tags.push_back(win);
    m_last_gnt = e_gnt;
    @(negedge clk_i);
  endtask

  initial begin
    clear_inputs();
    m_last_gnt = '0;

    // single request, single response
    do_reset();
    req_i = 2'b01; apu_gnt_i = 1'b1; op_a_i[31:0] = 32'h3F80_0000;
    #1;
    check("t1_gnt", gnt_o, 2'b01);
    check("t1_opa", apu_operands_1_o, 32'h3F80_0000);
    step();
    req_i = 2'b00; apu_gnt_i = 1'b0; apu_rvalid_i = 1'b1; apu_rdata_i = 32'h4000_0000;
    #1;
    check("t1_rvalid", rvalid_o, 2'b01);
    step();
    apu_rvalid_i = 1'b0;

    // round-robin alternation
    do_reset();
    req_i = 2'b11; apu_gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t2_gnt", gnt_o, (i % 2 == 0) ? 2'b01 : 2'b10);
      step();
    end
    req_i = 2'b00; apu_gnt_i = 1'b0; apu_rvalid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      apu_rdata_i = 32'(i + 1);
      step();
    end
    apu_rvalid_i = 1'b0;

    // stall keeps selection stable
    do_reset();
    req_i = 2'b11; op_code_i = {5'd2, 5'd1}; apu_gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t3_op", apu_op_o, 5'd1);
      check("t3_gnt", gnt_o, 2'b00);
      step();
    end
    apu_gnt_i = 1'b1;
    #1;
    check("t3_op", apu_op_o, 5'd1);
    check("t3_gnt", gnt_o, 2'b01);
    step();
    req_i = 2'b00; apu_gnt_i = 1'b0; apu_rvalid_i = 1'b1;
    step();
    apu_rvalid_i = 1'b0;

    // outstanding limit
    do_reset();
    req_i = 2'b01; apu_gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) step();
    apu_rvalid_i = 1'b1; apu_rdata_i = 32'hAA;
    #1;
    check("t4_full_req", apu_req_o, 1'b0);
    check("t4_full_busy", busy_o, 1'b1);
    check("t4_full_gnt", gnt_o, 2'b00);
    step();
    apu_rvalid_i = 1'b0;
    #1;
    check("t4_resume_req", apu_req_o, 1'b1);
    check("t4_resume_gnt", gnt_o, 2'b01);
    step();
    req_i = 2'b00; apu_gnt_i = 1'b0; apu_rvalid_i = 1'b1;
    for (int i = 0; i < 4; i++) step();
    apu_rvalid_i = 1'b0;
    #1;
    check("t4_idle_busy", busy_o, 1'b0);
    step();

    // in-order response routing
    do_reset();
    apu_gnt_i = 1'b1;
    req_i = 2'b10; step();
    req_i = 2'b01; step();
    req_i = 2'b10; step();
    req_i = 2'b00; apu_gnt_i = 1'b0; apu_rvalid_i = 1'b1;
    apu_rdata_i = 32'h11; #1;
    check("t5_rv0", rvalid_o, 2'b10); check("t5_rd0", rdata_o, 32'h11); step();
    apu_rdata_i = 32'h22; #1;
    check("t5_rv1", rvalid_o, 2'b01); check("t5_rd1", rdata_o, 32'h22); step();
    apu_rdata_i = 32'h33; #1;
    check("t5_rv2", rvalid_o, 2'b10); check("t5_rd2", rdata_o, 32'h33); step();
    apu_rvalid_i = 1'b0;

    // spurious response sets the sticky error
    do_reset();
    apu_rvalid_i = 1'b1;
    #1;
    check("t6_rvalid", rvalid_o, 2'b00);
    step();
    apu_rvalid_i = 1'b0;
    #1;
    check("t6_err", err_o, 1'b1);
    step();
    do_reset();

    // random traffic with a mid-run reset
    for (int n = 0; n < 1500; n++) begin
      if (n == 750) do_reset();
      for (int k = 0; k < N_REQ; k++) begin
        if (m_last_gnt[k]) req_i[k] = 1'b0;
        if (!req_i[k] && $urandom_range(0, 2) != 0) begin
          req_i[k] = 1'b1;
          op_a_i[32*k +: 32]    = $urandom();
          op_b_i[32*k +: 32]    = $urandom();
          op_c_i[32*k +: 32]    = $urandom();
          op_code_i[5*k +: 5]   = 5'($urandom());
          rnd_mode_i[3*k +: 3]  = 3'($urandom());
        end
      end
      apu_gnt_i    = ($urandom_range(0, 3) != 0);
      apu_rvalid_i = (m_tags.size() > 0) ? ($urandom_range(0, 2) == 0)
                                         : ($urandom_range(0, 99) == 0);
      apu_rdata_i  = $urandom();
      apu_rflags_i = 5'($urandom());
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
